collision_event_queue: RTL and testbench

- Sits directly downstream of the ball/wall/hole hit-detection stage.
- Captures that stage's single-cycle collision pulses (ball-ball pair, ball-wall, ball-hole), serialises them through a small FIFO, and presents them one at a time over a valid/ready handshake to the move/physics resolver.
- Keeps per-frame event statistics and a saturating drop counter for debug on the 7-segment/LED path.

---
 rtl/collision_event_queue.sv | 148 ++++++++++++++
 tb/tb_collision_event_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_event_queue.sv
// Collision event queue: latches ball-ball/wall/hole hit pulses into per-type pending registers,
// arbitrates them into a show-ahead FIFO and tracks per-frame and dropped-event statistics.
module collision_event_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned NUM_BALLS = 3
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [NUM_BALLS:0]   balls_collide,
    input  logic [1:0][3:0]      Balls_col_ID,
    input  logic [NUM_BALLS:0]   ballwall_collide,
    input  logic [1:0]           collided_wall,
    input  logic [NUM_BALLS:0]   ballhole_collide,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [1:0]           evt_type,
    output logic [3:0]           evt_idA,
    output logic [3:0]           evt_idB,
    output logic [1:0]           evt_wall,
    output logic [NUM_BALLS:0]   evt_mask,
    output logic [CNT_W-1:0]     drop_count,
    output logic [CNT_W-1:0]     frame_events
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [1:0]         typ;
        logic [3:0]         id_a;
        logic [3:0]         id_b;
        logic [1:0]         wall;
        logic [NUM_BALLS:0] mask;
    } evt_t;

    evt_t             mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    evt_t             pend_bb, pend_bw, pend_bh;
    logic             flag_bb, flag_bw, flag_bh;
    logic [CNT_W-1:0] frame_cnt;

    logic             empty, full, pop, can_push, push;
    logic             push_bb, push_bw, push_bh;
    logic             arr_bb, arr_bw, arr_bh;
    logic             load_bb, load_bw, load_bh;
    logic [1:0]       n_drops;
    logic [CNT_W+1:0] drop_sum;
    logic [CNT_W-1:0] drop_next, frame_inc;
    evt_t             push_data, new_bb, new_bw, new_bh, head;

    function automatic logic [3:0] low_idx(input logic [NUM_BALLS:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = int'(NUM_BALLS); i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Show-ahead head; payload forced to zero while the queue is empty.
    assign head      = mem[rd_ptr[AW-1:0]];
    assign evt_valid = !empty;
    assign evt_type  = evt_valid ? head.typ  : '0;
    assign evt_idA   = evt_valid ? head.id_a : '0;
    assign evt_idB   = evt_valid ? head.id_b : '0;
    assign evt_wall  = evt_valid ? head.wall : '0;
    assign evt_mask  = evt_valid ? head.mask : '0;

    // Arbitration, capture decisions and counter next values.
    always_comb begin
        pop      = evt_valid && evt_ready;
        can_push = !full || pop;
        push_bh  = can_push && flag_bh;
        push_bb  = can_push && flag_bb && !flag_bh;
        push_bw  = can_push && flag_bw && !flag_bh && !flag_bb;
        push     = push_bh || push_bb || push_bw;

        push_data = pend_bw;
        if (push_bh)      push_data = pend_bh;
        else if (push_bb) push_data = pend_bb;

        arr_bb  = |balls_collide;
        arr_bw  = |ballwall_collide;
        arr_bh  = |ballhole_collide;
        load_bb = arr_bb && (!flag_bb || push_bb);
        load_bw = arr_bw && (!flag_bw || push_bw);
        load_bh = arr_bh && (!flag_bh || push_bh);

        new_bb = '{typ: 2'b01, id_a: Balls_col_ID[0], id_b: Balls_col_ID[1],
                   wall: 2'b00, mask: balls_collide};
        new_bw = '{typ: 2'b10, id_a: low_idx(ballwall_collide), id_b: 4'd0,
                   wall: collided_wall, mask: ballwall_collide};
        new_bh = '{typ: 2'b11, id_a: low_idx(ballhole_collide), id_b: 4'd0,
                   wall: 2'b00, mask: ballhole_collide};

        n_drops   = 2'(arr_bb && !load_bb) + 2'(arr_bw && !load_bw) + 2'(arr_bh && !load_bh);
        drop_sum  = {2'b00, drop_count} + (CNT_W+2)'(n_drops);
        drop_next = (|drop_sum[CNT_W+1:CNT_W]) ? '1 : drop_sum[CNT_W-1:0];
        frame_inc = (&frame_cnt) ? frame_cnt : frame_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            flag_bb      <= 1'b0;
            flag_bw      <= 1'b0;
            flag_bh      <= 1'b0;
            pend_bb      <= '0;
            pend_bw      <= '0;
            pend_bh      <= '0;
            drop_count   <= '0;
            frame_cnt    <= '0;
            frame_events <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            if (load_bb)      begin flag_bb <= 1'b1; pend_bb <= new_bb; end
            else if (push_bb) flag_bb <= 1'b0;
            if (load_bw)      begin flag_bw <= 1'b1; pend_bw <= new_bw; end
            else if (push_bw) flag_bw <= 1'b0;
            if (load_bh)      begin flag_bh <= 1'b1; pend_bh <= new_bh; end
            else if (push_bh) flag_bh <= 1'b0;

            drop_count <= drop_next;

            // A push coinciding with frame start belongs to the new frame.
            if (startOfFrame) begin
                frame_events <= frame_cnt;
                frame_cnt    <= push ? CNT_W'(1) : '0;
            end else if (push) begin
                frame_cnt <= frame_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: tb/tb_collision_event_queue.sv
// Bench for collision_event_queue: directed scenarios plus random traffic checked every cycle
// against a queue-based reference model of the event pipeline.
module tb_collision_event_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned NB    = 3;

    logic             clk = 1'b0;
    logic             resetN;
    logic             startOfFrame;
    logic [NB:0]      balls_collide;
    logic [1:0][3:0]  Balls_col_ID;
    logic [NB:0]      ballwall_collide;
    logic [1:0]       collided_wall;
    logic [NB:0]      ballhole_collide;
    logic             evt_valid;
    logic             evt_ready;
    logic [1:0]       evt_type;
    logic [3:0]       evt_idA;
    logic [3:0]       evt_idB;
    logic [1:0]       evt_wall;
    logic [NB:0]      evt_mask;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] frame_events;

    always #5 clk = ~clk;

    collision_event_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .NUM_BALLS(NB)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .balls_collide(balls_collide), .Balls_col_ID(Balls_col_ID),
        .ballwall_collide(ballwall_collide), .collided_wall(collided_wall),
        .ballhole_collide(ballhole_collide), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_type(evt_type), .evt_idA(evt_idA), .evt_idB(evt_idB), .evt_wall(evt_wall),
        .evt_mask(evt_mask), .drop_count(drop_count), .frame_events(frame_events)
    );

    typedef struct {
        int typ;
        int ida;
        int idb;
        int wall;
        int mask;
    } ev_t;

    // Reference model: pending slot per kind (0=ball-ball, 1=ball-wall, 2=ball-hole) and an event queue.
    ev_t q[$];
    ev_t pend[3];
    bit  pv[3];
    int  m_drop, m_fcnt, m_fev;
    int  errors = 0;
    int  checks = 0;
    int  max_cnt = (1 << CNT_W) - 1;

    function automatic int lowest(input int v);
        for (int i = 0; i <= int'(NB); i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int t = 0; t < 3; t++) pv[t] = 1'b0;
        m_drop = 0;
        m_fcnt = 0;
        m_fev  = 0;
    endtask

    task automatic check_outputs();
        chk("evt_valid", 32'(evt_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("evt_type", 32'(evt_type), 32'(q[0].typ));
            chk("evt_idA",  32'(evt_idA),  32'(q[0].ida));
            chk("evt_idB",  32'(evt_idB),  32'(q[0].idb));
            chk("evt_wall", 32'(evt_wall), 32'(q[0].wall));
            chk("evt_mask", 32'(evt_mask), 32'(q[0].mask));
        end
        chk("drop_count",   32'(drop_count),   32'(m_drop));
        chk("frame_events", 32'(frame_events), 32'(m_fev));
    endtask

    task automatic model_step();
        bit  pop, can_push;
        int  sel;
        int  vec[3];
        ev_t nev[3];
        pop      = (q.size() > 0) && evt_ready;
        can_push = (q.size() < int'(DEPTH)) || pop;
        sel = -1;
        if (can_push) begin
            if (pv[2])      sel = 2;
            else if (pv[0]) sel = 0;
            else if (pv[1]) sel = 1;
        end
        if (pop) void'(q.pop_front());
        if (sel >= 0) q.push_back(pend[sel]);

        vec[0] = int'(balls_collide);
        vec[1] = int'(ballwall_collide);
        vec[2] = int'(ballhole_collide);
        nev[0] = '{1, int'(Balls_col_ID[0]), int'(Balls_col_ID[1]), 0, vec[0]};
        nev[1] = '{2, lowest(vec[1]), 0, int'(collided_wall), vec[1]};
        nev[2] = '{3, lowest(vec[2]), 0, 0, vec[2]};
        for (int t = 0; t < 3; t++) begin
            if (vec[t] != 0) begin
                if (pv[t] && sel != t) begin
                    if (m_drop < max_cnt) m_drop++;
                end else begin
                    pend[t] = nev[t];
                    pv[t]   = 1'b1;
                end
            end else if (sel == t) begin
                pv[t] = 1'b0;
            end
        end

        if (startOfFrame) begin
            m_fev  = m_fcnt;
            m_fcnt = (sel >= 0) ? 1 : 0;
        end else if (sel >= 0 && m_fcnt < max_cnt) begin
            m_fcnt++;
        end
    endtask

    // Called just after a falling edge: check, advance model, advance DUT by one clock.
    task automatic cycle();
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        balls_collide    = '0;
        Balls_col_ID     = '0;
        ballwall_collide = '0;
        collided_wall    = '0;
        ballhole_collide = '0;
        startOfFrame     = 1'b0;
    endtask

    task automatic idle(input int n);
        quiet();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd0);
        chk({tag, "_type"},  32'(evt_type),  32'd0);
        chk({tag, "_idA"},   32'(evt_idA),   32'd0);
        chk({tag, "_idB"},   32'(evt_idB),   32'd0);
        chk({tag, "_wall"},  32'(evt_wall),  32'd0);
        chk({tag, "_mask"},  32'(evt_mask),  32'd0);
        chk({tag, "_drop"},  32'(drop_count),   32'd0);
        chk({tag, "_frame"}, 32'(frame_events), 32'd0);
    endtask

    initial begin
        resetN    = 1'b0;
        evt_ready = 1'b1;
        quiet();
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        resetN = 1'b1;

        // Single ball-ball event: valid two cycles after the pulse, gone one cycle later.
        balls_collide = 4'b0011;
        Balls_col_ID  = {4'd1, 4'd0};
        cycle();
        idle(5);

        // All three kinds in one cycle drain hole, ball, wall.
        balls_collide    = 4'b0110;
        Balls_col_ID     = {4'd2, 4'd1};
        ballwall_collide = 4'b0100;
        collided_wall    = 2'b10;
        ballhole_collide = 4'b1000;
        cycle();
        idle(6);
        chk("no_drop_simultaneous", 32'(drop_count), 32'd0);

        // Fill the queue under backpressure: eight queued, one pending, one dropped.
        evt_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            quiet();
            ballwall_collide = 4'b0100;
            collided_wall    = 2'b10;
            cycle();
            idle(1);
        end
        idle(3);
        chk("drop_after_fill", 32'(drop_count), 32'd1);
        evt_ready = 1'b1;
        idle(12);
        chk("drained", 32'(evt_valid), 32'd0);

        // Back-to-back ball-ball pulses: second loads while the first pushes.
        balls_collide = 4'b0011;
        Balls_col_ID  = {4'd1, 4'd0};
        cycle();
        balls_collide = 4'b1100;
        Balls_col_ID  = {4'd3, 4'd2};
        cycle();
        idle(5);
        chk("no_drop_b2b", 32'(drop_count), 32'd1);

        // Frame statistics: five events, then an empty frame.
        startOfFrame = 1'b1;
        cycle();
        for (int k = 0; k < 5; k++) begin
            quiet();
            ballhole_collide = 4'(1 << (k % 4));
            cycle();
            idle(1);
        end
        idle(4);
        startOfFrame = 1'b1;
        cycle();
        quiet();
        chk("frame_five", 32'(frame_events), 32'd5);
        idle(6);
        startOfFrame = 1'b1;
        cycle();
        quiet();
        chk("frame_zero", 32'(frame_events), 32'd0);

        // Random traffic with random backpressure and frame starts.
        for (int k = 0; k < 400; k++) begin
            quiet();
            if ($urandom_range(0, 3) == 0) begin
                balls_collide = 4'($urandom_range(1, 15));
                Balls_col_ID  = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                ballwall_collide = 4'($urandom_range(1, 15));
                collided_wall    = 2'($urandom);
            end
            if ($urandom_range(0, 4) == 0) ballhole_collide = 4'($urandom_range(1, 15));
            startOfFrame = ($urandom_range(0, 19) == 0);
            evt_ready    = ($urandom_range(0, 3) != 0);
            cycle();
        end
        evt_ready = 1'b1;
        idle(14);

        // Asynchronous reset with events queued.
        evt_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            quiet();
            ballhole_collide = 4'b0010;
            cycle();
            idle(1);
        end
        idle(2);
        chk("queued_before_reset", 32'(evt_valid), 32'd1);
        resetN = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        resetN    = 1'b1;
        evt_ready = 1'b1;
        balls_collide = 4'b1001;
        Balls_col_ID  = {4'd3, 4'd0};
        cycle();
        quiet();
        chk("post_reset_t1", 32'(evt_valid), 32'd0);
        cycle();
        chk("post_reset_t2", 32'(evt_valid), 32'd1);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
